// File: rtl/spi_frame_scheduler_if.sv
// Handshake bundle between the counter-side requester, the frame scheduler
// and the SPI byte shift engine.
interface spi_frame_scheduler_if;
  logic        i_send;
  logic [13:0] i_data;
  logic        i_tx_done;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        o_ss;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_dropped;

  modport slave (
    input  i_send, i_data, i_tx_done,
    output o_tx_start, o_tx_data, o_ss, o_busy, o_frame_done, o_dropped
  );

  modport master (
    output i_send, i_data, i_tx_done,
    input  o_tx_start, o_tx_data, o_ss, o_busy, o_frame_done, o_dropped
  );
endinterface

// File: rtl/spi_frame_scheduler.sv
// Frames a 14-bit counter value as one SPI transaction (two bytes, high first)
// with slave-select setup time, a minimum inter-frame gap and a one-deep pending slot.
//
// state   | meaning
// IDLE    | o_ss high, waiting for i_send
// SETUP   | o_ss low, counting SS_SETUP_CYCLES before the first byte
// SEND_HI | byte0 {2'b00, data[13:8]} launched, waiting for i_tx_done
// SEND_LO | byte1 data[7:0] launched, waiting for i_tx_done
// GAP     | o_ss high for GAP_CYCLES; last cycle may relaunch directly
module spi_frame_scheduler #(
  parameter int unsigned SS_SETUP_CYCLES = 4,
  parameter int unsigned GAP_CYCLES      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_frame_scheduler_if.slave  bus
);

  localparam int unsigned CNT_MAX = (SS_SETUP_CYCLES > GAP_CYCLES) ? SS_SETUP_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SS_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SEND_HI = 3'd2,
    SEND_LO = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [13:0]      frame_q;
  logic             pend_valid_q;
  logic [13:0]      pend_data_q;
  logic             ss_q;
  logic             tx_start_q;
  logic [7:0]       tx_data_q;
  logic             busy_q;
  logic             frame_done_q;
  logic             dropped_q;
  logic             last_gap;

  assign last_gap = (state_q == GAP) && (cnt_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      frame_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      ss_q         <= 1'b1;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      dropped_q    <= 1'b0;

      // The last GAP cycle is excluded: there i_send launches directly instead.
      if (bus.i_send && (state_q != IDLE) && !last_gap) begin
        pend_data_q  <= bus.i_data;
        pend_valid_q <= 1'b1;
        dropped_q    <= pend_valid_q;
      end

      case (state_q)
        IDLE: begin
          if (bus.i_send) begin
            frame_q <= bus.i_data;
            cnt_q   <= SETUP_LOAD;
            ss_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= {2'b00, frame_q[13:8]};
            state_q    <= SEND_HI;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        SEND_HI: begin
          if (bus.i_tx_done) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= frame_q[7:0];
            state_q    <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (bus.i_tx_done) begin
            ss_q         <= 1'b1;
            frame_done_q <= 1'b1;
            cnt_q        <= GAP_LOAD;
            state_q      <= GAP;
          end
        end
        GAP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (bus.i_send || pend_valid_q) begin
            // A fresh request beats the pending one; the pending one is dropped.
            frame_q      <= bus.i_send ? bus.i_data : pend_data_q;
            dropped_q    <= bus.i_send && pend_valid_q;
            pend_valid_q <= 1'b0;
            cnt_q        <= SETUP_LOAD;
            ss_q         <= 1'b0;
            state_q      <= SETUP;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_tx_start   = tx_start_q;
  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_ss         = ss_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_frame_done = frame_done_q;
  assign bus.o_dropped    = dropped_q;

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Self-checking bench for spi_frame_scheduler: directed scenarios plus randomized
// request streams compared against a transaction-level timeline model.
module tb_spi_frame_scheduler;
  localparam int S = 4;
  localparam int G = 16;

  typedef struct {
    int          t;
    logic [13:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  spi_frame_scheduler_if bus();
  spi_frame_scheduler #(.SS_SETUP_CYCLES(S), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int dly = 10;
  int done_due = -1;
  logic [13:0] send_map[int];
  bit          spur_map[int];

  int          m_start[$];
  logic [7:0]  m_byte[$];
  int          m_ss_fall[$];
  int          m_ss_rise[$];
  int          m_fdone[$];
  int          m_busy_fall[$];
  int          m_drops = 0;
  int          stab_err = 0;
  bit          waiting = 0;
  logic [7:0]  cur_byte = '0;
  logic        prev_ss = 1'b1;
  logic        prev_busy = 1'b0;

  ev_t         evs[$];
  int          e_launch[$];
  logic [13:0] e_data[$];
  int          e_busy_fall[$];
  int          e_drops = 0;
  int          e_end = 0;

  // Byte-engine model and observation, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      waiting = 0;
    end else begin
      if (bus.o_tx_start) begin
        m_start.push_back(cyc);
        m_byte.push_back(bus.o_tx_data);
        cur_byte = bus.o_tx_data;
        done_due = cyc + dly;
        waiting = 1;
      end else if (waiting && bus.o_tx_data !== cur_byte) begin
        stab_err++;
      end
      if (waiting && bus.i_tx_done && !bus.o_tx_start) waiting = 0;
      if (prev_ss && !bus.o_ss) m_ss_fall.push_back(cyc);
      if (!prev_ss && bus.o_ss) m_ss_rise.push_back(cyc);
      if (bus.o_frame_done) m_fdone.push_back(cyc);
      if (prev_busy && !bus.o_busy) m_busy_fall.push_back(cyc);
      if (bus.o_dropped) m_drops++;
    end
    prev_ss = bus.o_ss;
    prev_busy = bus.o_busy;
  end

  task automatic run_until(input int last);
    while (cyc < last) begin
      @(posedge clk);
      #1;
      bus.i_send    = send_map.exists(cyc);
      bus.i_data    = send_map.exists(cyc) ? send_map[cyc] : 14'($urandom);
      bus.i_tx_done = (cyc == done_due) || spur_map.exists(cyc);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    m_start.delete(); m_byte.delete(); m_ss_fall.delete(); m_ss_rise.delete();
    m_fdone.delete(); m_busy_fall.delete();
    m_drops = 0; stab_err = 0;
    send_map.delete(); spur_map.delete();
  endtask

  function automatic int frame_len(input int d);
    return 1 + S + d + 1 + d + G;
  endfunction

  // Timeline model: each frame occupies a fixed number of cycles from its launch
  // cycle to its last gap cycle; requests in between go to a one-deep slot.
  function automatic void run_model(input int d);
    int          e_cur = 0;
    bit          active = 0;
    bit          pv = 0;
    logic [13:0] pd = '0;
    e_launch.delete(); e_data.delete(); e_busy_fall.delete(); e_drops = 0;
    foreach (evs[i]) begin
      while (active && evs[i].t > e_cur) begin
        if (pv) begin
          e_launch.push_back(e_cur); e_data.push_back(pd); pv = 0;
          e_cur = e_cur + frame_len(d);
        end else begin
          active = 0; e_busy_fall.push_back(e_cur + 1);
        end
      end
      if (!active) begin
        e_launch.push_back(evs[i].t); e_data.push_back(evs[i].d);
        active = 1; e_cur = evs[i].t + frame_len(d);
      end else if (evs[i].t == e_cur) begin
        if (pv) e_drops++;
        pv = 0;
        e_launch.push_back(e_cur); e_data.push_back(evs[i].d);
        e_cur = e_cur + frame_len(d);
      end else begin
        if (pv) e_drops++;
        pv = 1; pd = evs[i].d;
      end
    end
    while (active) begin
      if (pv) begin
        e_launch.push_back(e_cur); e_data.push_back(pd); pv = 0;
        e_cur = e_cur + frame_len(d);
      end else begin
        active = 0; e_busy_fall.push_back(e_cur + 1);
      end
    end
    e_end = e_cur;
  endfunction

  task automatic test_reset();
    bus.i_send = 0; bus.i_data = '0; bus.i_tx_done = 0;
    #1 reset = 1'b1;
    #1;
    tests++; if (bus.o_ss !== 1'b1) begin fails++; $display("FAIL reset_ss: got %b expected 1", bus.o_ss); end
    tests++; if (bus.o_tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start: got %b expected 0", bus.o_tx_start); end
    tests++; if (bus.o_tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h expected 00", bus.o_tx_data); end
    tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
    tests++; if (bus.o_frame_done !== 1'b0 || bus.o_dropped !== 1'b0) begin fails++; $display("FAIL reset_pulses: got %b%b expected 00", bus.o_frame_done, bus.o_dropped); end
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    run_until(cyc + 4);
    tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b expected 0", bus.o_busy); end
  endtask

  task automatic test_single_frame();
    int t;
    clear_mon(); dly = 10;
    t = cyc + 2; send_map[t] = 14'h2A5C;
    run_until(t + 55);
    tests++; if (m_start.size() !== 2) begin fails++; $display("FAIL single_starts: got %0d expected 2", m_start.size()); end
    else begin
      tests++; if (m_byte[0] !== 8'h2A || m_byte[1] !== 8'h5C) begin fails++; $display("FAIL single_bytes: got %h %h expected 2a 5c", m_byte[0], m_byte[1]); end
      tests++; if (m_start[0] !== t + 5) begin fails++; $display("FAIL single_start0: got %0d expected %0d", m_start[0], t + 5); end
      tests++; if (m_start[1] !== t + 16) begin fails++; $display("FAIL single_start1: got %0d expected %0d", m_start[1], t + 16); end
    end
    tests++; if (m_fdone.size() !== 1 || m_fdone[0] !== t + 27) begin fails++; $display("FAIL single_fdone: got n=%0d first=%0d expected n=1 at %0d", m_fdone.size(), m_fdone[0], t + 27); end
    tests++; if (m_ss_fall.size() !== 1 || m_ss_fall[0] !== t + 1 || m_ss_rise[0] !== t + 27) begin fails++; $display("FAIL single_ss: got fall=%0d rise=%0d expected %0d %0d", m_ss_fall[0], m_ss_rise[0], t + 1, t + 27); end
    tests++; if (m_busy_fall.size() !== 1 || m_busy_fall[0] !== t + 43) begin fails++; $display("FAIL single_busy: got %0d expected %0d", m_busy_fall[0], t + 43); end
    tests++; if (stab_err !== 0) begin fails++; $display("FAIL single_txdata_stable: got %0d glitches expected 0", stab_err); end
  endtask

  task automatic test_request_during_frame();
    int t;
    clear_mon(); dly = 10;
    t = cyc + 2; send_map[t] = 14'h3FFF; send_map[t + 7] = 14'h0123;
    run_until(t + 95);
    tests++; if (m_start.size() !== 4) begin fails++; $display("FAIL during_starts: got %0d expected 4", m_start.size()); end
    else begin
      tests++; if (m_byte[2] !== 8'h01 || m_byte[3] !== 8'h23) begin fails++; $display("FAIL during_bytes: got %h %h expected 01 23", m_byte[2], m_byte[3]); end
      tests++; if (m_start[2] !== t + 47) begin fails++; $display("FAIL during_start2: got %0d expected %0d", m_start[2], t + 47); end
    end
    tests++; if (m_ss_fall.size() !== 2 || m_ss_fall[1] - m_ss_rise[0] !== G) begin fails++; $display("FAIL during_ss_gap: got %0d expected %0d", m_ss_fall[1] - m_ss_rise[0], G); end
    tests++; if (m_drops !== 0) begin fails++; $display("FAIL during_drops: got %0d expected 0", m_drops); end
  endtask

  task automatic test_overflow();
    int t;
    clear_mon(); dly = 10;
    t = cyc + 2; send_map[t] = 14'h1555; send_map[t + 8] = 14'h0001; send_map[t + 20] = 14'h0002;
    run_until(t + 95);
    tests++; if (m_drops !== 1) begin fails++; $display("FAIL overflow_drops: got %0d expected 1", m_drops); end
    tests++; if (m_start.size() !== 4) begin fails++; $display("FAIL overflow_starts: got %0d expected 4", m_start.size()); end
    else begin
      tests++; if (m_byte[2] !== 8'h00 || m_byte[3] !== 8'h02) begin fails++; $display("FAIL overflow_bytes: got %h %h expected 00 02", m_byte[2], m_byte[3]); end
    end
  endtask

  task automatic test_last_gap();
    int t;
    clear_mon(); dly = 10;
    t = cyc + 2; send_map[t] = 14'h0AAA; send_map[t + 9] = 14'h0010; send_map[t + 42] = 14'h0020;
    run_until(t + 95);
    tests++; if (m_drops !== 1) begin fails++; $display("FAIL lastgap_drops: got %0d expected 1", m_drops); end
    tests++; if (m_start.size() !== 4) begin fails++; $display("FAIL lastgap_starts: got %0d expected 4", m_start.size()); end
    else begin
      tests++; if (m_byte[2] !== 8'h00 || m_byte[3] !== 8'h20) begin fails++; $display("FAIL lastgap_bytes: got %h %h expected 00 20", m_byte[2], m_byte[3]); end
      tests++; if (m_start[2] !== t + 47) begin fails++; $display("FAIL lastgap_start2: got %0d expected %0d", m_start[2], t + 47); end
    end
    tests++; if (m_busy_fall.size() !== 1 || m_busy_fall[0] !== t + 85) begin fails++; $display("FAIL lastgap_busy: got n=%0d at %0d expected n=1 at %0d", m_busy_fall.size(), m_busy_fall[0], t + 85); end
  endtask

  task automatic test_spurious_done();
    int t;
    clear_mon(); dly = 10;
    t = cyc + 3; send_map[t] = 14'h1234;
    spur_map[t - 1] = 1; spur_map[t + 2] = 1; spur_map[t + 30] = 1;
    run_until(t + 55);
    tests++; if (m_start.size() !== 2) begin fails++; $display("FAIL spur_starts: got %0d expected 2", m_start.size()); end
    else begin
      tests++; if (m_start[0] !== t + 5 || m_start[1] !== t + 16) begin fails++; $display("FAIL spur_start_times: got %0d %0d expected %0d %0d", m_start[0], m_start[1], t + 5, t + 16); end
    end
    tests++; if (m_busy_fall.size() !== 1 || m_busy_fall[0] !== t + 43) begin fails++; $display("FAIL spur_busy: got %0d expected %0d", m_busy_fall[0], t + 43); end
  endtask

  task automatic test_reset_mid_frame();
    int t;
    clear_mon(); dly = 10;
    t = cyc + 2; send_map[t] = 14'h1234; send_map[t + 8] = 14'h0777;
    run_until(t + 18);
    tests++; if (m_start.size() !== 2) begin fails++; $display("FAIL midrst_pre_starts: got %0d expected 2", m_start.size()); end
    reset = 1'b1;
    #1;
    tests++; if (bus.o_ss !== 1'b1 || bus.o_busy !== 1'b0) begin fails++; $display("FAIL midrst_outputs: got ss=%b busy=%b expected ss=1 busy=0", bus.o_ss, bus.o_busy); end
    done_due = -1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    clear_mon();
    t = cyc + 3; send_map[t] = 14'h0F0F;
    run_until(t + 60);
    tests++; if (m_start.size() !== 2) begin fails++; $display("FAIL midrst_starts: got %0d expected 2", m_start.size()); end
    else begin
      tests++; if (m_byte[0] !== 8'h0F || m_byte[1] !== 8'h0F) begin fails++; $display("FAIL midrst_bytes: got %h %h expected 0f 0f", m_byte[0], m_byte[1]); end
      tests++; if (m_start[0] !== t + 5) begin fails++; $display("FAIL midrst_start0: got %0d expected %0d", m_start[0], t + 5); end
    end
    tests++; if (m_drops !== 0 || m_fdone.size() !== 1) begin fails++; $display("FAIL midrst_drops_fdone: got %0d %0d expected 0 1", m_drops, m_fdone.size()); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int t;
      int n;
      clear_mon(); evs.delete();
      dly = $urandom_range(1, 12);
      t = cyc + 2;
      for (int k = 0; k < 8; k++) begin
        ev_t e;
        e.t = t; e.d = 14'($urandom);
        evs.push_back(e); send_map[t] = e.d;
        t = t + $urandom_range(1, 45);
      end
      run_model(dly);
      run_until(e_end + 5);
      n = e_data.size();
      tests++; if (m_start.size() !== 2 * n) begin fails++; $display("FAIL rnd%0d_starts: got %0d expected %0d", it, m_start.size(), 2 * n); end
      else begin
        for (int i = 0; i < n; i++) begin
          int st0;
          int k_done;
          st0 = e_launch[i] + 1 + S;
          k_done = st0 + dly + 1 + dly;
          tests++; if (m_byte[2*i] !== {2'b00, e_data[i][13:8]} || m_byte[2*i+1] !== e_data[i][7:0]) begin fails++; $display("FAIL rnd%0d_bytes[%0d]: got %h %h expected data %h", it, i, m_byte[2*i], m_byte[2*i+1], e_data[i]); end
          tests++; if (m_start[2*i] !== st0 || m_start[2*i+1] !== st0 + dly + 1) begin fails++; $display("FAIL rnd%0d_start[%0d]: got %0d %0d expected %0d %0d", it, i, m_start[2*i], m_start[2*i+1], st0, st0 + dly + 1); end
          tests++; if (m_ss_fall[i] !== e_launch[i] + 1 || m_ss_rise[i] !== k_done + 1 || m_fdone[i] !== k_done + 1) begin fails++; $display("FAIL rnd%0d_ss_fdone[%0d]: got fall=%0d rise=%0d fdone=%0d expected %0d %0d", it, i, m_ss_fall[i], m_ss_rise[i], m_fdone[i], e_launch[i] + 1, k_done + 1); end
        end
      end
      tests++; if (m_drops !== e_drops) begin fails++; $display("FAIL rnd%0d_drops: got %0d expected %0d", it, m_drops, e_drops); end
      tests++; if (m_fdone.size() !== n) begin fails++; $display("FAIL rnd%0d_fdone_count: got %0d expected %0d", it, m_fdone.size(), n); end
      tests++; if (m_busy_fall != e_busy_fall) begin fails++; $display("FAIL rnd%0d_busy_falls: got n=%0d expected n=%0d", it, m_busy_fall.size(), e_busy_fall.size()); end
      tests++; if (stab_err !== 0) begin fails++; $display("FAIL rnd%0d_txdata_stable: got %0d glitches expected 0", it, stab_err); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_request_during_frame();
    test_overflow();
    test_last_gap();
    test_spurious_done();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
